// File: rtl/instr_fetch.sv
// instr_fetch: program counter and sequencer for the instruction path.
// Drives the combinational instruction ROM address. Uses the decoder's
// halt (Ack) and branch (BranchEn/BranchIdx) outputs for the word at that
// address. Branch targets come from a 16-entry writable lookup table. The
// block runs the Start/Done handshake and counts executed RUN cycles.
//
// Handshake: Start is a one-cycle request that is honoured only in IDLE or
// DONE. Running is high for every cycle the fetched word is live.
// Done stays high from the cycle after the halt until the next Start.
module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              BranchEn,
  input  logic [3:0]        BranchIdx,
  input  logic              LutWrEn,
  input  logic [3:0]        LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   InstAddr,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_q [16];
  logic [PC_W-1:0]   lut_d [16];
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   branch_target;

  // LUT read uses the registered contents, so a same-cycle write to the
  // branch index is not seen until the following cycle.
  always_comb begin
    branch_target = lut_q[BranchIdx];
  end

  // LUT next contents: a write in any state replaces one entry.
  always_comb begin
    lut_d = lut_q;
    if (LutWrEn) begin
      lut_d[LutAddr] = LutData;
    end
  end

  // Sequencer next state, program counter and cycle counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // The halt cycle is counted like any other executed cycle.
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (Ack) begin
          // Halt wins over a simultaneous branch; stay on the halt word.
          state_d = ST_DONE;
        end else if (BranchEn) begin
          pc_d = branch_target;
        end else begin
          // Natural modulo-2^PC_W wrap.
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags registered alongside the state they decode.
  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, PC, counter and status registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // LUT storage, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        lut_q[i] <= lut_d[i];
      end
    end
  end

  assign InstAddr   = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch with hand-computed results.
module tb_instr_fetch;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic              Ack;
  logic              BranchEn;
  logic [3:0]        BranchIdx;
  logic              LutWrEn;
  logic [3:0]        LutAddr;
  logic [PC_W-1:0]   LutData;
  logic [PC_W-1:0]   InstAddr;
  logic              Running;
  logic              Done;
  logic [CNT_W-1:0]  CycleCount;

  // Behavioural ROM/decoder: one halt address and one branch address.
  logic              ack_en;
  logic [PC_W-1:0]   halt_addr;
  logic              br_en;
  logic [PC_W-1:0]   br_addr;
  logic [3:0]        br_idx;

  int n_checks;
  int n_fail;

  assign Ack       = ack_en && (InstAddr == halt_addr);
  assign BranchEn  = br_en && (InstAddr == br_addr);
  assign BranchIdx = br_idx;

  instr_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Ack        (Ack),
    .BranchEn   (BranchEn),
    .BranchIdx  (BranchIdx),
    .LutWrEn    (LutWrEn),
    .LutAddr    (LutAddr),
    .LutData    (LutData),
    .InstAddr   (InstAddr),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lut_write(input logic [3:0] idx, input logic [PC_W-1:0] val);
    LutWrEn = 1'b1;
    LutAddr = idx;
    LutData = val;
    tick();
    LutWrEn = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b1;
    Start     = 1'b0;
    LutWrEn   = 1'b0;
    LutAddr   = '0;
    LutData   = '0;
    ack_en    = 1'b0;
    halt_addr = '0;
    br_en     = 1'b0;
    br_addr   = '0;
    br_idx    = '0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_addr", 32'(InstAddr), 32'h0);
    check("rst_running", 32'(Running), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_cnt", 32'(CycleCount), 32'h0);

    // Straight-line program halting at address 3
    ack_en = 1'b1; halt_addr = 10'd3;
    pulse_start();
    check("t1_first_addr", 32'(InstAddr), 32'h0);
    check("t1_first_running", 32'(Running), 32'h1);
    check("t1_first_cnt", 32'(CycleCount), 32'h0);
    tick(); check("t1_addr1", 32'(InstAddr), 32'h1);
    tick(); check("t1_addr2", 32'(InstAddr), 32'h2);
    tick(); check("t1_addr3", 32'(InstAddr), 32'h3);
    check("t1_cnt3", 32'(CycleCount), 32'h3);
    tick();
    check("t1_done", 32'(Done), 32'h1);
    check("t1_running_low", 32'(Running), 32'h0);
    check("t1_halt_addr", 32'(InstAddr), 32'h3);
    check("t1_cnt", 32'(CycleCount), 32'h4);
    tick();
    check("t1_hold_addr", 32'(InstAddr), 32'h3);
    check("t1_hold_cnt", 32'(CycleCount), 32'h4);

    // Branch through LUT[5]
    lut_write(4'd5, 10'h120);
    ack_en = 1'b1; halt_addr = 10'h122;
    br_en = 1'b1; br_addr = 10'd2; br_idx = 4'd5;
    pulse_start();
    check("t2_restart_addr", 32'(InstAddr), 32'h0);
    check("t2_restart_cnt", 32'(CycleCount), 32'h0);
    tick(); tick();
    check("t2_at_branch", 32'(InstAddr), 32'h2);
    tick(); check("t2_target", 32'(InstAddr), 32'h120);
    tick(); check("t2_after_target", 32'(InstAddr), 32'h121);
    tick(); tick();
    check("t2_done", 32'(Done), 32'h1);
    check("t2_halt_addr", 32'(InstAddr), 32'h122);
    check("t2_cnt", 32'(CycleCount), 32'h6);

    // Start held into RUN is ignored; halt beats branch at one address
    ack_en = 1'b1; halt_addr = 10'd1;
    br_en = 1'b1; br_addr = 10'd1; br_idx = 4'd5;
    Start = 1'b1;
    tick();
    check("t3_restart_addr", 32'(InstAddr), 32'h0);
    tick();
    Start = 1'b0;
    check("t3_start_in_run_addr", 32'(InstAddr), 32'h1);
    check("t3_start_in_run_cnt", 32'(CycleCount), 32'h1);
    tick();
    check("t3_done", 32'(Done), 32'h1);
    check("t3_no_branch", 32'(InstAddr), 32'h1);
    check("t3_cnt", 32'(CycleCount), 32'h2);

    // Wrap from 0x3FF to 0x000
    lut_write(4'd0, 10'h3FF);
    ack_en = 1'b0;
    br_en = 1'b1; br_addr = 10'd2; br_idx = 4'd0;
    pulse_start();
    tick(); tick(); tick();
    check("t4_max_addr", 32'(InstAddr), 32'h3FF);
    tick();
    check("t4_wrap_addr", 32'(InstAddr), 32'h0);
    check("t4_wrap_running", 32'(Running), 32'h1);
    ack_en = 1'b1; halt_addr = 10'd0;
    tick();
    check("t4_done", 32'(Done), 32'h1);
    check("t4_cnt", 32'(CycleCount), 32'h5);

    // Read-before-write on the LUT
    lut_write(4'd7, 10'h040);
    lut_write(4'd6, 10'h010);
    ack_en = 1'b0;
    br_en = 1'b1; br_addr = 10'd2; br_idx = 4'd7;
    pulse_start();
    tick(); tick();
    check("t5_at_branch", 32'(InstAddr), 32'h2);
    LutWrEn = 1'b1; LutAddr = 4'd7; LutData = 10'h050;
    tick();
    LutWrEn = 1'b0;
    check("t5_old_value", 32'(InstAddr), 32'h040);
    br_addr = 10'h040;
    tick();
    check("t5_new_value", 32'(InstAddr), 32'h050);
    br_addr = 10'h050; br_idx = 4'd6;
    tick();
    check("t6_at_0x010", 32'(InstAddr), 32'h010);

    // Reset mid-RUN with a coincident Start
    Reset = 1'b1; Start = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0;
    check("t6_rst_addr", 32'(InstAddr), 32'h0);
    check("t6_rst_running", 32'(Running), 32'h0);
    check("t6_rst_cnt", 32'(CycleCount), 32'h0);
    tick();
    check("t6_idle_running", 32'(Running), 32'h0);
    check("t6_idle_done", 32'(Done), 32'h0);

    // LUT[5] cleared: branch at address 1 returns to 0, not 0x120
    br_en = 1'b1; br_addr = 10'd1; br_idx = 4'd5;
    pulse_start();
    tick(); tick();
    check("t6_lut_cleared", 32'(InstAddr), 32'h0);
    check("t6_cnt", 32'(CycleCount), 32'h2);
    ack_en = 1'b1; halt_addr = 10'd0;
    tick();
    check("t6_done", 32'(Done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
